// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: bundles the requester side and the transmitter side of uart_tx_arb.
//   req[3:0]   - per-requester byte request
//   lock[3:0]  - per-requester message lock (keeps ownership while req stays high)
//   data[31:0] - requester bytes, requester i on data[8i+7:8i]
//   ack[3:0]   - one-cycle pulse, requester i's byte was launched
//   grant[3:0] - one-hot current owner, 0 when idle
//   busy       - arbiter FSM not idle
//   err        - one-cycle pulse on launch timeout
//   tx_start   - start strobe to the serial transmitter
//   tx_data    - byte handed to the transmitter
//   tx_ready   - transmitter ready (1) / busy (0)
// Modport slave is the arbiter's view; master is the requesters' and transmitter's view.
interface uart_tx_arb_if;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport slave (
        input  req,
        input  lock,
        input  data,
        input  tx_ready,
        output ack,
        output grant,
        output busy,
        output err,
        output tx_start,
        output tx_data
    );

    modport master (
        output req,
        output lock,
        output data,
        output tx_ready,
        input  ack,
        input  grant,
        input  busy,
        input  err,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-requester arbiter feeding one serial transmitter.
// A requester holding both lock and req keeps ownership across bytes; otherwise ownership
// rotates round-robin starting after the last owner. Each granted byte is launched with a
// single-cycle tx_start/ack, then the arbiter waits for the transmitter to go busy (bounded
// by TIMEOUT cycles, err on expiry) and to become ready again.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - uart_tx_arb_if.slave (requester handshake and transmitter strobe/data/ready)
module uart_tx_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_arb_if.slave  bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      owner_q, owner_d;
    logic [3:0]      grant_q, grant_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;

    logic [1:0]      winner;
    logic            found;
    logic [1:0]      idx;

    // Winner selection; only consumed in IDLE when req != 0.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        if (bus.req[last_q] && bus.lock[last_q]) begin
            winner = last_q;
        end else begin
            // k = 4 wraps onto last itself, which wins only if nobody else asks.
            for (int k = 1; k <= 4; k++) begin
                idx = last_q + k[1:0];
                if (!found && bus.req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.tx_ready && (bus.req != 4'b0000)) begin
                    owner_d   = winner;
                    grant_d   = 4'b0001 << winner;
                    tx_data_d = bus.data[{winner, 3'b000} +: 8];
                    state_d   = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!bus.tx_ready) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntMax) begin
                    timeout = 1'b1;
                    last_d  = owner_q;
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (bus.tx_ready) begin
                    last_d  = owner_q;
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 2'd3;
            owner_q   <= 2'd0;
            grant_q   <= 4'b0000;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Pulses are masked while rst is high so an abandoned transfer never emits ack or err.
    assign bus.tx_start = (state_q == StLaunch) && !rst;
    assign bus.ack      = bus.tx_start ? grant_q : 4'b0000;
    assign bus.err      = timeout && !rst;
    assign bus.busy     = (state_q != StIdle);
    assign bus.grant    = grant_q;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb (TIMEOUT = 16).
// tx_ready comes either from a transmitter model (busy for three cycles after each
// tx_start) or from a manually driven level. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_uart_tx_arb;

    logic clk;
    logic rst;
    logic manual;
    logic manual_ready;
    logic model_ready;

    int n_cmp;
    int n_err;

    uart_tx_arb_if bus ();

    uart_tx_arb #(
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_ready = manual ? manual_ready : model_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: goes busy right after a start strobe, ready again 3 cycles later.
    initial begin
        model_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                model_ready = 1'b0;
                repeat (3) @(negedge clk);
                model_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge inside the LAUNCH cycle.
    task automatic wait_start(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({tag, "_start_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int err_first;
        int err_cnt;
        int start_cnt;

        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        manual       = 1'b0;
        manual_ready = 1'b1;
        bus.req      = 4'b0000;
        bus.lock     = 4'b0000;
        bus.data     = 32'h0000_0000;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);

        // All four request: served 0,1,2,3
        rst      = 1'b0;
        bus.data = 32'h4443_4241;
        bus.req  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_start("rr", 20);
            chk("rr_tx_data", 32'(bus.tx_data), 32'h41 + 32'(i));
            chk("rr_ack", 32'(bus.ack), 32'h1 << i);
            chk("rr_grant", 32'(bus.grant), 32'h1 << i);
            chk("rr_busy", 32'(bus.busy), 32'h1);
            if (i == 3) bus.req = 4'b0000;
            @(negedge clk);
            chk("rr_ack_1cyc", 32'(bus.ack), 32'h0);
            chk("rr_start_1cyc", 32'(bus.tx_start), 32'h0);
            chk("rr_grant_held", 32'(bus.grant), 32'h1 << i);
        end
        wait_idle("rr", 20);
        chk("rr_grant_idle", 32'(bus.grant), 32'h0);

        // Lock: requester 2 keeps three bytes while requester 0 waits
        bus.data = 32'h00A0_0050;
        bus.lock = 4'b0100;
        bus.req  = 4'b0100;
        wait_start("lk1", 20);
        chk("lk1_grant", 32'(bus.grant), 32'h4);
        chk("lk1_tx_data", 32'(bus.tx_data), 32'hA0);
        bus.req = 4'b0101;
        wait_start("lk2", 20);
        chk("lk2_grant", 32'(bus.grant), 32'h4);
        chk("lk2_ack", 32'(bus.ack), 32'h4);
        wait_start("lk3", 20);
        chk("lk3_grant", 32'(bus.grant), 32'h4);
        bus.req  = 4'b0001;
        bus.lock = 4'b0000;
        wait_start("lk4", 20);
        chk("lk4_grant", 32'(bus.grant), 32'h1);
        chk("lk4_tx_data", 32'(bus.tx_data), 32'h50);
        bus.req = 4'b0000;
        wait_idle("lk", 20);

        // tx_ready low blocks arbitration
        manual       = 1'b1;
        manual_ready = 1'b0;
        bus.data     = 32'h0000_0011;
        bus.req      = 4'b0001;
        start_cnt    = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx_start) start_cnt++;
        end
        chk("rdy_no_start", 32'(start_cnt), 32'h0);
        chk("rdy_no_grant", 32'(bus.grant), 32'h0);
        chk("rdy_not_busy", 32'(bus.busy), 32'h0);
        manual_ready = 1'b1;
        @(negedge clk);
        chk("rdy_start", 32'(bus.tx_start), 32'h1);
        chk("rdy_grant", 32'(bus.grant), 32'h1);
        chk("rdy_tx_data", 32'(bus.tx_data), 32'h11);
        manual_ready = 1'b0;
        bus.req      = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rdy_wait_done_busy", 32'(bus.busy), 32'h1);
        manual_ready = 1'b1;
        wait_idle("rdy", 10);

        // Transmitter never goes busy: err exactly once, 16 cycles after tx_start
        bus.data = 32'h0000_2200;
        bus.req  = 4'b0010;
        wait_start("to", 20);
        chk("to_grant", 32'(bus.grant), 32'h2);
        bus.req   = 4'b0000;
        err_first = 0;
        err_cnt   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.err) begin
                err_cnt++;
                if (err_first == 0) err_first = i;
            end
        end
        chk("to_err_delay", 32'(err_first), 32'd16);
        chk("to_err_count", 32'(err_cnt), 32'd1);
        chk("to_busy", 32'(bus.busy), 32'h0);
        chk("to_grant_clr", 32'(bus.grant), 32'h0);

        // Reset during WAIT_DONE, pending req[1] granted afterwards
        bus.data = 32'h0000_0033;
        bus.req  = 4'b0001;
        wait_start("rs", 20);
        chk("rs_grant0", 32'(bus.grant), 32'h1);
        manual_ready = 1'b0;
        bus.req      = 4'b0010;
        bus.data     = 32'h0000_6633;
        repeat (2) @(negedge clk);
        chk("rs_in_wait_done", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_grant", 32'(bus.grant), 32'h0);
        chk("rs_busy", 32'(bus.busy), 32'h0);
        chk("rs_tx_start", 32'(bus.tx_start), 32'h0);
        chk("rs_ack", 32'(bus.ack), 32'h0);
        chk("rs_err", 32'(bus.err), 32'h0);
        chk("rs_tx_data", 32'(bus.tx_data), 32'h0);
        rst          = 1'b0;
        manual_ready = 1'b1;
        @(negedge clk);
        chk("rs_resume_start", 32'(bus.tx_start), 32'h1);
        chk("rs_resume_grant", 32'(bus.grant), 32'h2);
        chk("rs_resume_data", 32'(bus.tx_data), 32'h66);
        bus.req      = 4'b0000;
        manual_ready = 1'b0;
        repeat (2) @(negedge clk);
        manual_ready = 1'b1;
        wait_idle("rs", 10);

        // Data change during WAIT_DONE leaves the byte in flight alone
        manual = 1'b0;
        repeat (5) @(negedge clk);
        bus.data = 32'h7700_0000;
        bus.req  = 4'b1000;
        wait_start("hd", 20);
        chk("hd_grant", 32'(bus.grant), 32'h8);
        chk("hd_tx_data", 32'(bus.tx_data), 32'h77);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        bus.data = 32'h8800_0000;
        chk("hd_hold_busy", 32'(bus.tx_data), 32'h77);
        wait_idle("hd", 10);
        chk("hd_hold_idle", 32'(bus.tx_data), 32'h77);
        bus.req = 4'b1000;
        wait_start("hd2", 20);
        chk("hd_new_data", 32'(bus.tx_data), 32'h88);
        bus.req = 4'b0000;
        wait_idle("hd2", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for tx_ready to fall after a launch.
REQ-002 SHALL have port clk, input, 1, the system clock; it is the only clock.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port req, input, 4, the per-requester byte request; bit i belongs to requester i.
REQ-005 SHALL have port lock, input, 4, the per-requester message lock; bit i belongs to requester i.
REQ-006 SHALL have port data, input, 32, the requester bytes; requester i uses data[8i+7:8i].
REQ-007 SHALL have port ack, output, 4, a one-cycle pulse meaning requester i's byte was launched.
REQ-008 SHALL have port grant, output, 4, the one-hot current owner, or 0 when the block is idle.
REQ-009 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-010 SHALL have port err, output, 1, a one-cycle pulse raised on a launch timeout.
REQ-011 SHALL have port tx_start, output, 1, the start strobe to the serial transmitter.
REQ-012 SHALL have port tx_data, output, 8, the byte sent to the transmitter.
REQ-013 SHALL have port tx_ready, input, 1, the transmitter ready (1) / busy (0) flag.

Function
REQ-014 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE, arbitration SHALL occur only when tx_ready=1 and req!=0; otherwise the FSM SHALL remain in IDLE with grant=0.
REQ-016 The arbitration winner SHALL be chosen as follows:
- The last owner wins if both its lock and req bits are 1.
- Otherwise the winner is chosen round-robin, scanning from (last+1) mod 4 upward.
REQ-017 On arbitration, the block SHALL register tx_data <= the winner's data byte, set grant to the winner one-hot, and go to LAUNCH.
REQ-018 The grant SHALL remain held through WAIT_DONE.
REQ-019 LAUNCH SHALL last exactly one cycle, with tx_start=1 and ack[winner]=1 in that same cycle, then go to WAIT_BUSY with the timeout counter cleared.
REQ-020 Latency: a req sampled in IDLE at cycle t SHALL produce tx_start and ack at cycle t+1.
REQ-021 In WAIT_BUSY, tx_ready=0 SHALL move the FSM to WAIT_DONE; otherwise the counter SHALL increment.
REQ-022 When the counter reaches TIMEOUT-1 with tx_ready still 1, the block SHALL pulse err for one cycle, update last to the owner, clear grant and return to IDLE.
REQ-023 In WAIT_DONE, tx_ready=1 SHALL update last to the owner, clear grant and return to IDLE in the next cycle.
REQ-024 A lock bit whose req bit is 0 SHALL confer no priority; a locked owner with no req SHALL not stall the other requesters.
REQ-025 tx_data SHALL hold its value between grants; data changes after arbitration SHALL not affect the byte in flight.
REQ-026 Requester contract: req and data are held stable until ack; req may stay high after ack to request another byte, with new data valid by the next IDLE cycle.
REQ-027 Changes in req or lock during LAUNCH, WAIT_BUSY or WAIT_DONE SHALL be ignored; only IDLE samples them.
REQ-028 The outputs ack, tx_start and err SHALL never be high for more than one consecutive cycle.
REQ-029 At most one ack bit SHALL be high at any time.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 When rst=1 at a clk edge, the block SHALL set state=IDLE, grant=0, ack=0, busy=0, err=0, tx_start=0, tx_data=8'h00, counter=0 and last=3, so requester 0 has first priority.
REQ-032 A reset asserted mid-operation SHALL abandon the transfer with no ack or err pulse; arbitration SHALL resume on the first cycle after rst falls.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- After reset, req=4'b1111 with bytes 8'h41..8'h44 and the transmitter model running → bytes sent in order 0,1,2,3 (8'h41,8'h42,8'h43,8'h44); each ack is one cycle and aligned with tx_start.
- With lock[2]=1 and req[2]=1 held for 3 bytes while req[0]=1 → three consecutive grants to requester 2, then requester 0 is served.
- req=4'b0001 with tx_ready=0 → no tx_start while tx_ready=0; tx_start occurs one cycle after tx_ready rises.
- Transmitter stub that never drops tx_ready, TIMEOUT=16 → err pulses exactly once, 16 cycles after tx_start; the FSM returns to IDLE and grant=0.
- rst asserted during WAIT_DONE → next cycle grant=0, busy=0, tx_start=0; a pending req[1] is granted after rst is released.
- Requester 3 changes data during WAIT_DONE → tx_data is unchanged until the next grant.
